// File: rtl/calculator_pkg.sv
// Shared width parameters for the calculator datapath blocks.
package calculator_pkg;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned MEM_WORD_SIZE = 2 * DATA_W;
  localparam int unsigned ADDR_W        = 8;
endpackage

// File: rtl/operand_reader.sv
// Reads a run of 64-bit memory words and hands each one to the ALU as two
// 32-bit operands, lower half first, with a valid/ready handshake.
module operand_reader
  import calculator_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        base_addr_i,
  input  logic [ADDR_W-1:0]        num_words_i,
  output logic                     read_en_o,
  output logic [ADDR_W-1:0]        read_addr_o,
  input  logic [MEM_WORD_SIZE-1:0] read_data_i,
  output logic [DATA_W-1:0]        operand_o,
  output logic                     operand_valid_o,
  input  logic                     operand_ready_i,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    EMIT_LO,
    EMIT_HI,
    DONE
  } state_t;

  state_t                   state;
  state_t                   next_state;
  logic [ADDR_W-1:0]        addr;
  logic [ADDR_W-1:0]        remaining;
  logic [MEM_WORD_SIZE-1:0] word;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      word      <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && start_i && num_words_i != '0) begin
        addr      <= base_addr_i;
        remaining <= num_words_i;
      end
      if (state == LOAD) begin
        word <= read_data_i;
      end
      // Address wraps naturally at 2^ADDR_W.
      if (state == EMIT_HI && operand_ready_i) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - ADDR_W'(1);
      end
    end
  end

  // Outputs decode from state alone so an asynchronous reset clears them
  // immediately without waiting for an edge.
  always_comb begin
    next_state      = state;
    read_en_o       = 1'b0;
    read_addr_o     = '0;
    operand_o       = '0;
    operand_valid_o = 1'b0;
    busy_o          = 1'b1;
    done_o          = 1'b0;
    unique case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          next_state = (num_words_i != '0) ? FETCH : DONE;
        end
      end
      FETCH: begin
        read_en_o   = 1'b1;
        read_addr_o = addr;
        next_state  = LOAD;
      end
      LOAD: begin
        next_state = EMIT_LO;
      end
      EMIT_LO: begin
        operand_o       = word[DATA_W-1:0];
        operand_valid_o = 1'b1;
        if (operand_ready_i) begin
          next_state = EMIT_HI;
        end
      end
      EMIT_HI: begin
        operand_o       = word[MEM_WORD_SIZE-1:DATA_W];
        operand_valid_o = 1'b1;
        if (operand_ready_i) begin
          next_state = (remaining == ADDR_W'(1)) ? DONE : FETCH;
        end
      end
      DONE: begin
        done_o     = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule
